reservation_station: RTL and testbench
======================================

# reservation_station

Eight-entry, two-wide-dispatch reservation station between the dispatch stage and the single execute-unit port. Each cycle it accepts up to two renamed instructions, carrying their reorder-buffer tags and operand tags/values. It snoops both CDB broadcasts to capture pending operands. When the functional unit accepts, it issues one fully-ready instruction and frees that entry.

## Interface
- `RS_ENTRIES`, 8: number of station entries (free count sized for 0..8).
- `RSTAG_NULL`, 8'hFF: tag value meaning "operand already valid / no tag".
- `clock` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all entries immediately.
- `inst1_valid_in`, `inst2_valid_in` in 1 each: dispatch slot valid.
- `inst1_in`, `inst2_in` in 32 each: instruction word.
- `inst1_dest_tag_in`, `inst2_dest_tag_in` in 8 each: ROB tag of result.
- `inst1_opa_tag_in`, `inst1_opb_tag_in`, `inst2_opa_tag_in`, `inst2_opb_tag_in` in 8 each: producer tag, or `RSTAG_NULL` if the value is supplied.
- `inst1_opa_value_in`, `inst1_opb_value_in`, `inst2_opa_value_in`, `inst2_opb_value_in` in 64 each: operand value; used only when the matching tag is `RSTAG_NULL`.
- `cdb1_tag_in`, `cdb2_tag_in` in 8 each: broadcast tags (`RSTAG_NULL` = idle).
- `cdb1_value_in`, `cdb2_value_in` in 64 each: broadcast values.
- `fu_ready_in` in 1: functional unit accepts an issue this cycle.
- `issue_valid_out` out 1: an entry is issuing.
- `issue_inst_out` out 32, `issue_dest_tag_out` out 8, `issue_opa_value_out` out 64, `issue_opb_value_out` out 64: payload of the issuing entry.
- `rs_full` out 1: fewer than 2 free entries.
- `free_count_out` out 4: number of free entries.

## Operation
- Per-entry state:
  - `busy`
  - `inst`, `dest_tag`
  - per operand: `tag`, `value`, `ready`
- An operand is ready when its stored tag is `RSTAG_NULL` or it has been captured from the CDB.
- **Dispatch**:
  - Dispatch happens only when `rs_full`=0.
  - When `rs_full`=1, both slots are ignored and no state changes.
  - Slot 1 takes the lowest-index free entry. Slot 2 takes the next-lowest free entry.
  - If only slot 2 is valid, it takes the lowest-index free entry.
  - Free status is taken from the current (pre-edge) state. An entry freed by issue this cycle is not reallocated until the next cycle.
- **Dispatch-time forwarding**: if an incoming operand tag (≠`RSTAG_NULL`) equals `cdb1_tag_in` or `cdb2_tag_in` in the same cycle, the entry is written ready with the CDB value.
- **Wakeup**:
  - Every busy entry's non-ready operand compares its tag against both CDB tags. On a match, it latches that value and sets `ready`.
  - A CDB tag of `RSTAG_NULL` never matches.
  - If both CDB tags match the same operand, cdb1 wins.
- **Issue select**:
  - Candidates are busy entries with both operands ready in the registered state.
  - The lowest-index candidate drives the issue outputs combinationally. `issue_valid_out`=1 when any candidate exists.
  - An entry woken this cycle becomes a candidate next cycle.
- **Issue handshake**:
  - When `issue_valid_out` && `fu_ready_in`, the selected entry's `busy` is cleared at the edge.
  - When `fu_ready_in`=0, the outputs hold the same selection. A lower-index entry that becomes ready may preempt the selection on the next cycle; this is legal.
- **Counts**: `free_count_out` = `RS_ENTRIES` − popcount(`busy`). `rs_full` = (`free_count_out` < 2).
- When `issue_valid_out`=0, the payload outputs are zero.

## Timing
- Reset (asynchronous) clears all `busy`, `ready`, tags (set to `RSTAG_NULL`) and values. While and after reset:
  - `issue_valid_out`=0
  - all payload outputs = 0
  - `rs_full`=0
  - `free_count_out`=8
- Dispatch-to-issue minimum latency is 1 cycle: dispatched ready at edge N, `issue_valid_out` high in cycle N+1.
- CDB-to-issue latency is 1 cycle: broadcast in cycle N, issue is possible in cycle N+1.
- Simultaneous dispatch, wakeup and issue in one cycle are all legal and independent.
- When `free_count_out`=1, `rs_full`=1 and single dispatch is also refused.
- Reset asserted mid-operation discards all entries; nothing issues in the reset cycle.

## Test plan
- **Reset**: reset → `free_count_out`=8, `rs_full`=0, `issue_valid_out`=0, all payloads 0.
- **Ready dispatch**: dispatch inst1 (dest 8'h03, opa/opb tags FF, values 64'h5/64'h7) with `fu_ready_in`=1 → next cycle `issue_valid_out`=1, dest 8'h03, values 5/7. The cycle after, `free_count_out`=8.
- **CDB wakeup**: dispatch with opa tag 8'h04, opb ready; two cycles later `cdb2_tag_in`=8'h04, value 64'hAB → `issue_valid_out`=1 on the following cycle with opa=64'hAB. Before that, `issue_valid_out`=0.
- **Same-cycle forward**: dispatch opa tag 8'h09 while `cdb1_tag_in`=8'h09, value 64'h11 → issues the next cycle with opa 64'h11.
- **Full handling**: dual-dispatch 4 cycles with `fu_ready_in`=0 → `free_count_out`=0, `rs_full`=1. A fifth dispatch is ignored (count stays 0).
  - Raise `fu_ready_in` → entries issue in index order 0..7, one per cycle.
- **Priority/stall**: entries 2 and 5 ready, `fu_ready_in`=0 for 3 cycles → outputs hold entry 2. Raise `fu_ready_in` → entry 2 issues, then entry 5 next cycle.

Source files
------------

// File: rtl/reservation_station.sv
// reservation_station: eight-entry, two-wide-dispatch reservation station.
// It accepts up to two renamed instructions per cycle and snoops both CDBs
// to capture pending operands. It issues the lowest-index fully-ready entry
// to the single functional-unit port.
module reservation_station #(
    parameter int unsigned RS_ENTRIES = 8,
    parameter logic [7:0]  RSTAG_NULL = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        inst1_valid_in,
    input  logic        inst2_valid_in,
    input  logic [31:0] inst1_in,
    input  logic [31:0] inst2_in,
    input  logic [7:0]  inst1_dest_tag_in,
    input  logic [7:0]  inst2_dest_tag_in,
    input  logic [7:0]  inst1_opa_tag_in,
    input  logic [7:0]  inst1_opb_tag_in,
    input  logic [7:0]  inst2_opa_tag_in,
    input  logic [7:0]  inst2_opb_tag_in,
    input  logic [63:0] inst1_opa_value_in,
    input  logic [63:0] inst1_opb_value_in,
    input  logic [63:0] inst2_opa_value_in,
    input  logic [63:0] inst2_opb_value_in,

    input  logic [7:0]  cdb1_tag_in,
    input  logic [7:0]  cdb2_tag_in,
    input  logic [63:0] cdb1_value_in,
    input  logic [63:0] cdb2_value_in,

    input  logic        fu_ready_in,

    output logic        issue_valid_out,
    output logic [31:0] issue_inst_out,
    output logic [7:0]  issue_dest_tag_out,
    output logic [63:0] issue_opa_value_out,
    output logic [63:0] issue_opb_value_out,
    output logic        rs_full,
    output logic [3:0]  free_count_out
);

    localparam int unsigned INST_W = 32;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned VAL_W  = 64;
    localparam int unsigned IDX_W  = $clog2(RS_ENTRIES);
    localparam int unsigned CNT_W  = 4;

    // Entry storage
    logic [RS_ENTRIES-1:0] r_busy;
    logic [RS_ENTRIES-1:0] r_opa_rdy;
    logic [RS_ENTRIES-1:0] r_opb_rdy;
    logic [INST_W-1:0]     r_inst    [RS_ENTRIES];
    logic [TAG_W-1:0]      r_dest    [RS_ENTRIES];
    logic [TAG_W-1:0]      r_opa_tag [RS_ENTRIES];
    logic [TAG_W-1:0]      r_opb_tag [RS_ENTRIES];
    logic [VAL_W-1:0]      r_opa_val [RS_ENTRIES];
    logic [VAL_W-1:0]      r_opb_val [RS_ENTRIES];

    // Free-entry search and counts
    logic             w_free1_found;
    logic             w_free2_found;
    logic [IDX_W-1:0] w_free1_idx;
    logic [IDX_W-1:0] w_free2_idx;
    logic [CNT_W-1:0] w_free_cnt;
    logic             w_rs_full;

    // Dispatch control
    logic             w_slot1_we;
    logic             w_slot2_we;
    logic [IDX_W-1:0] w_slot1_idx;
    logic [IDX_W-1:0] w_slot2_idx;

    // Dispatch-time operand resolution: {ready, value}
    logic [VAL_W:0]   w_i1_opa;
    logic [VAL_W:0]   w_i1_opb;
    logic [VAL_W:0]   w_i2_opa;
    logic [VAL_W:0]   w_i2_opb;

    // Issue select
    logic             w_issue_valid;
    logic [IDX_W-1:0] w_issue_idx;
    logic             w_issue_fire;

    logic             w_cdb1_live;
    logic             w_cdb2_live;

    assign w_cdb1_live = (cdb1_tag_in != RSTAG_NULL);
    assign w_cdb2_live = (cdb2_tag_in != RSTAG_NULL);

    // An operand arriving with a real tag can still be satisfied by a
    // same-cycle broadcast; cdb1 has priority when both buses carry the tag.
    function automatic logic [VAL_W:0] f_resolve(
        input logic [TAG_W-1:0] tag,
        input logic [VAL_W-1:0] value,
        input logic             c1_live,
        input logic [TAG_W-1:0] c1_tag,
        input logic [VAL_W-1:0] c1_val,
        input logic             c2_live,
        input logic [TAG_W-1:0] c2_tag,
        input logic [VAL_W-1:0] c2_val
    );
        logic [VAL_W:0] res;
        if (tag == RSTAG_NULL) begin
            res = {1'b1, value};
        end else if (c1_live && (tag == c1_tag)) begin
            res = {1'b1, c1_val};
        end else if (c2_live && (tag == c2_tag)) begin
            res = {1'b1, c2_val};
        end else begin
            res = {1'b0, value};
        end
        return res;
    endfunction

    // Resolve the four incoming operands against the live broadcasts
    always_comb begin
        w_i1_opa = f_resolve(inst1_opa_tag_in, inst1_opa_value_in,
                             w_cdb1_live, cdb1_tag_in, cdb1_value_in,
                             w_cdb2_live, cdb2_tag_in, cdb2_value_in);
        w_i1_opb = f_resolve(inst1_opb_tag_in, inst1_opb_value_in,
                             w_cdb1_live, cdb1_tag_in, cdb1_value_in,
                             w_cdb2_live, cdb2_tag_in, cdb2_value_in);
        w_i2_opa = f_resolve(inst2_opa_tag_in, inst2_opa_value_in,
                             w_cdb1_live, cdb1_tag_in, cdb1_value_in,
                             w_cdb2_live, cdb2_tag_in, cdb2_value_in);
        w_i2_opb = f_resolve(inst2_opb_tag_in, inst2_opb_value_in,
                             w_cdb1_live, cdb1_tag_in, cdb1_value_in,
                             w_cdb2_live, cdb2_tag_in, cdb2_value_in);
    end

    // Find the two lowest-index free entries and count free entries
    always_comb begin
        w_free1_found = 1'b0;
        w_free2_found = 1'b0;
        w_free1_idx   = '0;
        w_free2_idx   = '0;
        w_free_cnt    = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            if (!r_busy[i]) begin
                w_free_cnt = w_free_cnt + CNT_W'(1);
                if (!w_free1_found) begin
                    w_free1_found = 1'b1;
                    w_free1_idx   = IDX_W'(i);
                end else if (!w_free2_found) begin
                    w_free2_found = 1'b1;
                    w_free2_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Two free entries are required before any dispatch, so both slots
    // always have a target whenever dispatch is allowed.
    always_comb begin
        w_rs_full   = (w_free_cnt < CNT_W'(2));
        w_slot1_we  = inst1_valid_in && !w_rs_full;
        w_slot2_we  = inst2_valid_in && !w_rs_full;
        w_slot1_idx = w_free1_idx;
        w_slot2_idx = inst1_valid_in ? w_free2_idx : w_free1_idx;
    end

    // Pick the lowest-index entry with both operands ready
    always_comb begin
        w_issue_valid = 1'b0;
        w_issue_idx   = '0;
        for (int i = 0; i < int'(RS_ENTRIES); i++) begin
            if (r_busy[i] && r_opa_rdy[i] && r_opb_rdy[i] && !w_issue_valid) begin
                w_issue_valid = 1'b1;
                w_issue_idx   = IDX_W'(i);
            end
        end
        w_issue_fire = w_issue_valid && fu_ready_in;
    end

    // Issue payload, forced to zero when nothing is selected
    always_comb begin
        issue_valid_out     = w_issue_valid;
        issue_inst_out      = '0;
        issue_dest_tag_out  = '0;
        issue_opa_value_out = '0;
        issue_opb_value_out = '0;
        if (w_issue_valid) begin
            issue_inst_out      = r_inst[w_issue_idx];
            issue_dest_tag_out  = r_dest[w_issue_idx];
            issue_opa_value_out = r_opa_val[w_issue_idx];
            issue_opb_value_out = r_opb_val[w_issue_idx];
        end
    end

    assign rs_full        = w_rs_full;
    assign free_count_out = w_free_cnt;

    // Entry update: wakeup of waiting operands, issue release, dispatch
    // allocation. Dispatch targets only non-busy entries while wakeup and
    // release touch only busy ones, so the three never collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_busy    <= '0;
            r_opa_rdy <= '0;
            r_opb_rdy <= '0;
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                r_inst[i]    <= '0;
                r_dest[i]    <= '0;
                r_opa_tag[i] <= RSTAG_NULL;
                r_opb_tag[i] <= RSTAG_NULL;
                r_opa_val[i] <= '0;
                r_opb_val[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(RS_ENTRIES); i++) begin
                if (r_busy[i] && !r_opa_rdy[i]) begin
                    if (w_cdb1_live && (cdb1_tag_in == r_opa_tag[i])) begin
                        r_opa_val[i] <= cdb1_value_in;
                        r_opa_rdy[i] <= 1'b1;
                    end else if (w_cdb2_live && (cdb2_tag_in == r_opa_tag[i])) begin
                        r_opa_val[i] <= cdb2_value_in;
                        r_opa_rdy[i] <= 1'b1;
                    end
                end
                if (r_busy[i] && !r_opb_rdy[i]) begin
                    if (w_cdb1_live && (cdb1_tag_in == r_opb_tag[i])) begin
                        r_opb_val[i] <= cdb1_value_in;
                        r_opb_rdy[i] <= 1'b1;
                    end else if (w_cdb2_live && (cdb2_tag_in == r_opb_tag[i])) begin
                        r_opb_val[i] <= cdb2_value_in;
                        r_opb_rdy[i] <= 1'b1;
                    end
                end
                if (w_issue_fire && (w_issue_idx == IDX_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end

            if (w_slot1_we) begin
                r_busy[w_slot1_idx]    <= 1'b1;
                r_inst[w_slot1_idx]    <= inst1_in;
                r_dest[w_slot1_idx]    <= inst1_dest_tag_in;
                r_opa_tag[w_slot1_idx] <= inst1_opa_tag_in;
                r_opb_tag[w_slot1_idx] <= inst1_opb_tag_in;
                r_opa_rdy[w_slot1_idx] <= w_i1_opa[VAL_W];
                r_opb_rdy[w_slot1_idx] <= w_i1_opb[VAL_W];
                r_opa_val[w_slot1_idx] <= w_i1_opa[VAL_W-1:0];
                r_opb_val[w_slot1_idx] <= w_i1_opb[VAL_W-1:0];
            end

            if (w_slot2_we) begin
                r_busy[w_slot2_idx]    <= 1'b1;
                r_inst[w_slot2_idx]    <= inst2_in;
                r_dest[w_slot2_idx]    <= inst2_dest_tag_in;
                r_opa_tag[w_slot2_idx] <= inst2_opa_tag_in;
                r_opb_tag[w_slot2_idx] <= inst2_opb_tag_in;
                r_opa_rdy[w_slot2_idx] <= w_i2_opa[VAL_W];
                r_opb_rdy[w_slot2_idx] <= w_i2_opb[VAL_W];
                r_opa_val[w_slot2_idx] <= w_i2_opa[VAL_W-1:0];
                r_opb_val[w_slot2_idx] <= w_i2_opb[VAL_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed test-plan sequences plus random
// traffic, checked cycle by cycle against a behavioural model through a
// queue of expected outputs.
module tb_reservation_station;

    localparam logic [7:0] NULLT = 8'hFF;

    logic        clock = 1'b0;
    logic        reset;
    logic        inst1_valid_in, inst2_valid_in;
    logic [31:0] inst1_in, inst2_in;
    logic [7:0]  inst1_dest_tag_in, inst2_dest_tag_in;
    logic [7:0]  inst1_opa_tag_in, inst1_opb_tag_in, inst2_opa_tag_in, inst2_opb_tag_in;
    logic [63:0] inst1_opa_value_in, inst1_opb_value_in, inst2_opa_value_in, inst2_opb_value_in;
    logic [7:0]  cdb1_tag_in, cdb2_tag_in;
    logic [63:0] cdb1_value_in, cdb2_value_in;
    logic        fu_ready_in;
    logic        issue_valid_out;
    logic [31:0] issue_inst_out;
    logic [7:0]  issue_dest_tag_out;
    logic [63:0] issue_opa_value_out, issue_opb_value_out;
    logic        rs_full;
    logic [3:0]  free_count_out;

    reservation_station dut (
        .clock(clock), .reset(reset),
        .inst1_valid_in(inst1_valid_in), .inst2_valid_in(inst2_valid_in),
        .inst1_in(inst1_in), .inst2_in(inst2_in),
        .inst1_dest_tag_in(inst1_dest_tag_in), .inst2_dest_tag_in(inst2_dest_tag_in),
        .inst1_opa_tag_in(inst1_opa_tag_in), .inst1_opb_tag_in(inst1_opb_tag_in),
        .inst2_opa_tag_in(inst2_opa_tag_in), .inst2_opb_tag_in(inst2_opb_tag_in),
        .inst1_opa_value_in(inst1_opa_value_in), .inst1_opb_value_in(inst1_opb_value_in),
        .inst2_opa_value_in(inst2_opa_value_in), .inst2_opb_value_in(inst2_opb_value_in),
        .cdb1_tag_in(cdb1_tag_in), .cdb2_tag_in(cdb2_tag_in),
        .cdb1_value_in(cdb1_value_in), .cdb2_value_in(cdb2_value_in),
        .fu_ready_in(fu_ready_in),
        .issue_valid_out(issue_valid_out), .issue_inst_out(issue_inst_out),
        .issue_dest_tag_out(issue_dest_tag_out),
        .issue_opa_value_out(issue_opa_value_out), .issue_opb_value_out(issue_opb_value_out),
        .rs_full(rs_full), .free_count_out(free_count_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [7:0]  dest;
        logic [7:0]  at;
        logic [7:0]  bt;
        logic [63:0] av;
        logic [63:0] bv;
    } disp_t;

    typedef struct {
        logic        busy;
        logic [31:0] inst;
        logic [7:0]  dest;
        logic [7:0]  at;
        logic [7:0]  bt;
        logic        ar;
        logic        br;
        logic [63:0] av;
        logic [63:0] bv;
    } ment_t;

    typedef struct {
        logic        v;
        logic [31:0] inst;
        logic [7:0]  dest;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  fc;
        logic        full;
    } exp_t;

    ment_t m [8];
    exp_t  exq [$];
    int    n_checks = 0;
    int    n_fail   = 0;
    disp_t NONE;

    // ---------------- reference model ----------------
    function automatic int m_select();
        for (int i = 0; i < 8; i++)
            if (m[i].busy && m[i].ar && m[i].br) return i;
        return -1;
    endfunction

    function automatic int m_free();
        int f = 0;
        for (int i = 0; i < 8; i++) if (!m[i].busy) f++;
        return f;
    endfunction

    function automatic exp_t m_expect();
        exp_t e;
        int s = m_select();
        int f = m_free();
        e.v = (s >= 0);
        e.inst = 0; e.dest = 0; e.a = 0; e.b = 0;
        if (s >= 0) begin
            e.inst = m[s].inst; e.dest = m[s].dest; e.a = m[s].av; e.b = m[s].bv;
        end
        e.fc = 4'(f);
        e.full = (f < 2);
        return e;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) begin
            m[i].busy = 0; m[i].ar = 0; m[i].br = 0;
            m[i].at = NULLT; m[i].bt = NULLT; m[i].av = 0; m[i].bv = 0;
            m[i].inst = 0; m[i].dest = 0;
        end
    endtask

    // Returns {hit, value} for a tag seen on the broadcast buses (cdb1 first).
    function automatic logic [64:0] bus_hit(input logic [7:0] tag,
            input logic [7:0] c1t, input logic [63:0] c1v,
            input logic [7:0] c2t, input logic [63:0] c2v);
        if (c1t != NULLT && c1t == tag) return {1'b1, c1v};
        if (c2t != NULLT && c2t == tag) return {1'b1, c2v};
        return {1'b0, 64'h0};
    endfunction

    task automatic m_alloc(input int k, input disp_t d,
            input logic [7:0] c1t, input logic [63:0] c1v,
            input logic [7:0] c2t, input logic [63:0] c2v);
        logic [64:0] h;
        m[k].busy = 1; m[k].inst = d.inst; m[k].dest = d.dest;
        m[k].at = d.at; m[k].bt = d.bt;
        if (d.at == NULLT) begin m[k].ar = 1; m[k].av = d.av; end
        else begin h = bus_hit(d.at, c1t, c1v, c2t, c2v); m[k].ar = h[64]; m[k].av = h[63:0]; end
        if (d.bt == NULLT) begin m[k].br = 1; m[k].bv = d.bv; end
        else begin h = bus_hit(d.bt, c1t, c1v, c2t, c2v); m[k].br = h[64]; m[k].bv = h[63:0]; end
    endtask

    // One clock edge of the model, using the state as it was before the edge.
    task automatic m_step(input disp_t d1, input disp_t d2,
            input logic [7:0] c1t, input logic [63:0] c1v,
            input logic [7:0] c2t, input logic [63:0] c2v, input logic fu);
        int s = m_select();
        int f = m_free();
        int fq[$];
        logic [64:0] h;
        for (int i = 0; i < 8; i++) if (!m[i].busy) fq.push_back(i);
        for (int i = 0; i < 8; i++) begin
            if (m[i].busy && !m[i].ar) begin
                h = bus_hit(m[i].at, c1t, c1v, c2t, c2v);
                if (h[64]) begin m[i].ar = 1; m[i].av = h[63:0]; end
            end
            if (m[i].busy && !m[i].br) begin
                h = bus_hit(m[i].bt, c1t, c1v, c2t, c2v);
                if (h[64]) begin m[i].br = 1; m[i].bv = h[63:0]; end
            end
        end
        if (s >= 0 && fu) m[s].busy = 0;
        if (f >= 2) begin
            if (d1.v) m_alloc(fq.pop_front(), d1, c1t, c1v, c2t, c2v);
            if (d2.v) m_alloc(fq.pop_front(), d2, c1t, c1v, c2t, c2v);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic disp_t mk(input logic v, input logic [31:0] inst, input logic [7:0] dest,
            input logic [7:0] at, input logic [7:0] bt, input logic [63:0] av, input logic [63:0] bv);
        disp_t d;
        d.v = v; d.inst = inst; d.dest = dest; d.at = at; d.bt = bt; d.av = av; d.bv = bv;
        return d;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs for this cycle,
    // then advance the model across the edge.
    task automatic cycle(input disp_t d1, input disp_t d2,
            input logic [7:0] c1t, input logic [63:0] c1v,
            input logic [7:0] c2t, input logic [63:0] c2v, input logic fu);
        inst1_valid_in = d1.v; inst1_in = d1.inst; inst1_dest_tag_in = d1.dest;
        inst1_opa_tag_in = d1.at; inst1_opb_tag_in = d1.bt;
        inst1_opa_value_in = d1.av; inst1_opb_value_in = d1.bv;
        inst2_valid_in = d2.v; inst2_in = d2.inst; inst2_dest_tag_in = d2.dest;
        inst2_opa_tag_in = d2.at; inst2_opb_tag_in = d2.bt;
        inst2_opa_value_in = d2.av; inst2_opb_value_in = d2.bv;
        cdb1_tag_in = c1t; cdb1_value_in = c1v;
        cdb2_tag_in = c2t; cdb2_value_in = c2v;
        fu_ready_in = fu;
        exq.push_back(m_expect());
        @(posedge clock); #1;
        m_step(d1, d2, c1t, c1v, c2t, c2v, fu);
    endtask

    task automatic idle(input logic fu);
        cycle(NONE, NONE, NULLT, 64'h0, NULLT, 64'h0, fu);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("midrst_valid", 64'(issue_valid_out), 64'd0);
        chk("midrst_free", 64'(free_count_out), 64'd8);
        m_clear();
        exq.push_back(m_expect());
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    function automatic logic [7:0] rtag();
        if ($urandom_range(0, 2) == 0) return NULLT;
        return 8'($urandom_range(0, 15));
    endfunction

    function automatic logic [7:0] rcdb();
        if ($urandom_range(0, 1) == 0) return NULLT;
        return 8'($urandom_range(0, 15));
    endfunction

    function automatic disp_t rdisp();
        return mk(1'($urandom_range(0, 1)), $urandom, 8'($urandom), rtag(), rtag(),
                  {$urandom, $urandom}, {$urandom, $urandom});
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exq.size() > 0) begin
                e = exq.pop_front();
                n_checks++;
                if (issue_valid_out !== e.v || issue_inst_out !== e.inst ||
                    issue_dest_tag_out !== e.dest || issue_opa_value_out !== e.a ||
                    issue_opb_value_out !== e.b) begin
                    n_fail++;
                    $display("FAIL issue @%0t: got v=%0b inst=%h dest=%h a=%h b=%h, expected v=%0b inst=%h dest=%h a=%h b=%h",
                             $time, issue_valid_out, issue_inst_out, issue_dest_tag_out,
                             issue_opa_value_out, issue_opb_value_out,
                             e.v, e.inst, e.dest, e.a, e.b);
                end
                n_checks++;
                if (free_count_out !== e.fc || rs_full !== e.full) begin
                    n_fail++;
                    $display("FAIL counts @%0t: got free=%0d full=%0b, expected free=%0d full=%0b",
                             $time, free_count_out, rs_full, e.fc, e.full);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        disp_t da, db;
        NONE = mk(1'b0, 32'h0, 8'h0, NULLT, NULLT, 64'h0, 64'h0);
        reset = 1'b1;
        inst1_valid_in = 0; inst2_valid_in = 0; inst1_in = 0; inst2_in = 0;
        inst1_dest_tag_in = 0; inst2_dest_tag_in = 0;
        inst1_opa_tag_in = NULLT; inst1_opb_tag_in = NULLT;
        inst2_opa_tag_in = NULLT; inst2_opb_tag_in = NULLT;
        inst1_opa_value_in = 0; inst1_opb_value_in = 0;
        inst2_opa_value_in = 0; inst2_opb_value_in = 0;
        cdb1_tag_in = NULLT; cdb2_tag_in = NULLT; cdb1_value_in = 0; cdb2_value_in = 0;
        fu_ready_in = 0;
        m_clear();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_free", 64'(free_count_out), 64'd8);
        chk("rst_full", 64'(rs_full), 64'd0);
        chk("rst_valid", 64'(issue_valid_out), 64'd0);
        chk("rst_inst", 64'(issue_inst_out), 64'd0);
        chk("rst_dest", 64'(issue_dest_tag_out), 64'd0);
        chk("rst_opa", issue_opa_value_out, 64'd0);
        chk("rst_opb", issue_opb_value_out, 64'd0);
        reset = 1'b0;

        // Ready dispatch
        cycle(mk(1, 32'h100, 8'h03, NULLT, NULLT, 64'h5, 64'h7), NONE, NULLT, 0, NULLT, 0, 1);
        chk("rd_valid", 64'(issue_valid_out), 64'd1);
        chk("rd_dest", 64'(issue_dest_tag_out), 64'h03);
        chk("rd_opa", issue_opa_value_out, 64'h5);
        chk("rd_opb", issue_opb_value_out, 64'h7);
        idle(1);
        chk("rd_free", 64'(free_count_out), 64'd8);

        // CDB wakeup via cdb2
        cycle(mk(1, 32'h200, 8'h11, 8'h04, NULLT, 64'h0, 64'h2), NONE, NULLT, 0, NULLT, 0, 1);
        chk("wk_wait1", 64'(issue_valid_out), 64'd0);
        idle(1);
        chk("wk_wait2", 64'(issue_valid_out), 64'd0);
        cycle(NONE, NONE, NULLT, 0, 8'h04, 64'hAB, 1);
        chk("wk_valid", 64'(issue_valid_out), 64'd1);
        chk("wk_opa", issue_opa_value_out, 64'hAB);
        idle(1);

        // Same-cycle forward from cdb1
        cycle(mk(1, 32'h300, 8'h12, 8'h09, NULLT, 64'h0, 64'h3), NONE, 8'h09, 64'h11, NULLT, 0, 1);
        chk("fw_valid", 64'(issue_valid_out), 64'd1);
        chk("fw_opa", issue_opa_value_out, 64'h11);
        idle(1);

        // Fill to full, refused dispatch, then drain in index order
        for (int k = 0; k < 4; k++)
            cycle(mk(1, 32'(32'h400 + 2*k), 8'(32'h20 + 2*k), NULLT, NULLT, 64'(k), 64'(k)),
                  mk(1, 32'(32'h401 + 2*k), 8'(32'h21 + 2*k), NULLT, NULLT, 64'(k), 64'(k)),
                  NULLT, 0, NULLT, 0, 0);
        chk("full_free", 64'(free_count_out), 64'd0);
        chk("full_flag", 64'(rs_full), 64'd1);
        cycle(mk(1, 32'h4FF, 8'h30, NULLT, NULLT, 0, 0), mk(1, 32'h4FE, 8'h31, NULLT, NULLT, 0, 0),
              NULLT, 0, NULLT, 0, 0);
        chk("full_refuse", 64'(free_count_out), 64'd0);
        for (int k = 0; k < 8; k++) begin
            chk("drain_order", 64'(issue_dest_tag_out), 64'(32'h20 + k));
            idle(1);
        end
        chk("drain_free", 64'(free_count_out), 64'd8);

        // Priority and stall: only entries 2 and 5 ready
        for (int k = 0; k < 4; k++) begin
            da = mk(1, 32'(32'h500 + 2*k), 8'(32'h50 + 2*k),
                    (2*k == 2) ? NULLT : 8'h40, NULLT, 64'(2*k), 64'h1);
            db = mk(1, 32'(32'h501 + 2*k), 8'(32'h51 + 2*k),
                    (2*k+1 == 5) ? NULLT : 8'h40, NULLT, 64'(2*k+1), 64'h1);
            cycle(da, db, NULLT, 0, NULLT, 0, 0);
        end
        chk("prio_sel", 64'(issue_dest_tag_out), 64'h52);
        for (int k = 0; k < 3; k++) begin
            idle(0);
            chk("stall_hold", 64'(issue_dest_tag_out), 64'h52);
        end
        idle(1);
        chk("prio_next", 64'(issue_dest_tag_out), 64'h55);
        idle(1);
        chk("prio_none", 64'(issue_valid_out), 64'd0);
        cycle(NONE, NONE, 8'h40, 64'h44, NULLT, 0, 1);
        repeat (7) idle(1);
        chk("prio_free", 64'(free_count_out), 64'd8);

        // Random traffic with occasional mid-operation reset
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else cycle(rdisp(), rdisp(), rcdb(), {$urandom, $urandom}, rcdb(), {$urandom, $urandom},
                       ($urandom_range(0, 3) != 0));
        end

        @(negedge clock);
        #1;
        chk("queue_empty", 64'(exq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
